// File: rtl/decode_stage.sv
// MIPS-subset decode stage: combinational decode feeding one output register, with load-use
// bubble insertion, flush kill and a saturating bubble counter.
module decode_stage #(
  parameter int XLEN      = 32,
  parameter int HAZARD_EN = 1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [XLEN-1:0]  in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [9:0]       out_ctrl,
  output logic [4:0]       out_rs,
  output logic [4:0]       out_rt,
  output logic [4:0]       out_dest,
  output logic [XLEN-1:0]  out_imm,
  output logic [XLEN-1:0]  out_pc,
  output logic [CNT_W-1:0] bubble_cnt
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_LUI  = 6'b001111;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  logic [5:0]      w_op;
  logic [5:0]      w_funct;
  logic [1:0]      w_pc_src;
  logic            w_we, w_alu_src_b, w_reg_dst, w_mem_write, w_mem_to_reg;
  logic [2:0]      w_alu;
  logic [XLEN-1:0] w_imm;
  logic            w_rd_rs, w_rd_rt;
  logic [4:0]      w_dest;
  logic            w_adv, w_hazard;

  logic            r_valid;
  logic [9:0]      r_ctrl;
  logic [4:0]      r_rs, r_rt, r_dest;
  logic [XLEN-1:0] r_imm, r_pc;
  logic [CNT_W-1:0] r_bub;

  assign w_op    = in_inst[31:26];
  assign w_funct = in_inst[5:0];

  always_comb begin
    w_pc_src     = 2'd0;
    w_we         = 1'b0;
    w_alu_src_b  = 1'b0;
    w_reg_dst    = 1'b0;
    w_mem_write  = 1'b0;
    w_mem_to_reg = 1'b0;
    w_alu        = 3'b000;
    w_imm        = '0;
    w_rd_rs      = 1'b1;
    w_rd_rt      = 1'b0;
    case (w_op)
      OP_R: begin
        w_we      = (w_funct != 6'b000000);
        w_reg_dst = 1'b1;
        w_rd_rt   = 1'b1;
        case (w_funct)
          6'b100000: w_alu = 3'b010;
          6'b100010: w_alu = 3'b110;
          6'b100100: w_alu = 3'b000;
          6'b100101: w_alu = 3'b001;
          6'b101010: w_alu = 3'b111;
          default:   w_alu = 3'b000;
        endcase
      end
      OP_ADDI, OP_SLTI: begin
        w_we        = 1'b1;
        w_alu_src_b = 1'b1;
        w_alu       = (w_op == OP_ADDI) ? 3'b010 : 3'b111;
        w_imm       = XLEN'($signed(in_inst[15:0]));
      end
      OP_ANDI, OP_ORI: begin
        w_we        = 1'b1;
        w_alu_src_b = 1'b1;
        w_alu       = (w_op == OP_ANDI) ? 3'b000 : 3'b001;
        w_imm       = XLEN'(in_inst[15:0]);
      end
      OP_LUI: begin
        w_we        = 1'b1;
        w_alu_src_b = 1'b1;
        w_alu       = 3'b011;
        w_imm       = XLEN'({in_inst[15:0], 16'h0000});
        w_rd_rs     = 1'b0;
      end
      OP_BEQ, OP_BNE: begin
        w_pc_src = (w_op == OP_BEQ) ? 2'd1 : 2'd3;
        w_alu    = 3'b110;
        w_imm    = XLEN'($signed(in_inst[15:0]));
        w_rd_rt  = 1'b1;
      end
      OP_J: begin
        w_pc_src = 2'd2;
        w_imm    = XLEN'(in_inst[25:0]);
        w_rd_rs  = 1'b0;
      end
      OP_LW: begin
        w_we         = 1'b1;
        w_alu_src_b  = 1'b1;
        w_mem_to_reg = 1'b1;
        w_alu        = 3'b010;
        w_imm        = XLEN'($signed(in_inst[15:0]));
      end
      OP_SW: begin
        w_alu_src_b = 1'b1;
        w_mem_write = 1'b1;
        w_alu       = 3'b010;
        w_imm       = XLEN'($signed(in_inst[15:0]));
        w_rd_rt     = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_dest = !w_we ? 5'd0 : (w_reg_dst ? in_inst[15:11] : in_inst[20:16]);

  // Only a registered lw with a real destination can stall the instruction behind it.
  assign w_adv    = out_ready || !r_valid;
  assign w_hazard = (HAZARD_EN != 0) && r_valid && r_ctrl[3] && (r_dest != 5'd0) && in_valid &&
                    ((w_rd_rs && (in_inst[25:21] == r_dest)) ||
                     (w_rd_rt && (in_inst[20:16] == r_dest)));
  assign in_ready = nrst && (flush || (w_adv && !w_hazard));

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
      r_rs    <= '0;
      r_rt    <= '0;
      r_dest  <= '0;
      r_imm   <= '0;
      r_pc    <= '0;
      r_bub   <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_adv) begin
      if (w_hazard) begin
        r_valid <= 1'b0;
        if (r_bub != '1) r_bub <= r_bub + CNT_W'(1);
      end else if (in_valid) begin
        r_valid <= 1'b1;
        r_ctrl  <= {w_pc_src, w_we, w_alu_src_b, w_reg_dst, w_mem_write, w_mem_to_reg, w_alu};
        r_rs    <= in_inst[25:21];
        r_rt    <= in_inst[20:16];
        r_dest  <= w_dest;
        r_imm   <= w_imm;
        r_pc    <= in_pc;
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out_valid  = r_valid;
  assign out_ctrl   = r_ctrl;
  assign out_rs     = r_rs;
  assign out_rt     = r_rt;
  assign out_dest   = r_dest;
  assign out_imm    = r_imm;
  assign out_pc     = r_pc;
  assign bubble_cnt = r_bub;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode vectors, stall hold, load-use bubbles, flush,
// counter saturation and asynchronous reset.
module tb_decode_stage;
  localparam int XLEN  = 32;
  localparam int CNT_W = 2;

  localparam logic [31:0] ADD1 = 32'h00221820, LW   = 32'h8C22FFFC, ADD2 = 32'h00441820;
  localparam logic [31:0] LUI  = 32'h3C051234, BEQ  = 32'h1022FFFF, ORI  = 32'h34278001;
  localparam logic [31:0] JMP  = 32'h0BFFFFFF, NOPR = 32'h00221800, BAD  = 32'hFFFFFFFF;
  localparam logic [31:0] SUB  = 32'h00222022, SW   = 32'hAC220008, JRS  = 32'h08400000;
  localparam logic [31:0] ADDI = 32'h20A20001, LW0  = 32'h8C20FFFC, ADD0 = 32'h00001820;

  logic             clk = 1'b0;
  logic             nrst = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_inst = 32'h0;
  logic [XLEN-1:0]  in_pc = '0;
  logic             flush = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [9:0]       out_ctrl;
  logic [4:0]       out_rs, out_rt, out_dest;
  logic [XLEN-1:0]  out_imm, out_pc;
  logic [CNT_W-1:0] bubble_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(XLEN), .HAZARD_EN(1), .CNT_W(CNT_W)) dut (
    .clk(clk), .nrst(nrst), .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
    .in_pc(in_pc), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_rs(out_rs), .out_rt(out_rt), .out_dest(out_dest),
    .out_imm(out_imm), .out_pc(out_pc), .bubble_cnt(bubble_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] inst, input logic [XLEN-1:0] pc);
    in_valid = v;
    in_inst  = inst;
    in_pc    = pc;
    #1;
  endtask

  task automatic bundle(input string tag, input logic [9:0] ctrl, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] dest,
                        input logic [XLEN-1:0] imm, input logic [XLEN-1:0] pc);
    chk({tag, ".valid"}, 64'(out_valid), 64'd1);
    chk({tag, ".ctrl"},  64'(out_ctrl),  64'(ctrl));
    chk({tag, ".rs"},    64'(out_rs),    64'(rs));
    chk({tag, ".rt"},    64'(out_rt),    64'(rt));
    chk({tag, ".dest"},  64'(out_dest),  64'(dest));
    chk({tag, ".imm"},   64'(out_imm),   64'(imm));
    chk({tag, ".pc"},    64'(out_pc),    64'(pc));
  endtask

  task automatic all_zero(input string tag);
    chk({tag, ".valid"}, 64'(out_valid), 64'd0);
    chk({tag, ".ctrl"},  64'(out_ctrl), 64'd0);
    chk({tag, ".rs"},    64'(out_rs), 64'd0);
    chk({tag, ".rt"},    64'(out_rt), 64'd0);
    chk({tag, ".dest"},  64'(out_dest), 64'd0);
    chk({tag, ".imm"},   64'(out_imm), 64'd0);
    chk({tag, ".pc"},    64'(out_pc), 64'd0);
    chk({tag, ".bub"},   64'(bubble_cnt), 64'd0);
    chk({tag, ".in_ready"}, 64'(in_ready), 64'd0);
  endtask

  initial begin
    int exp_bub;
    // Reset held with an instruction presented
    drive(1'b1, ADD1, 32'h100);
    tick(); tick();
    all_zero("reset");
    nrst = 1'b1;
    #1;
    chk("first_accept.in_ready", 64'(in_ready), 64'd1);

    // Decode vectors
    tick(); bundle("add", 10'h0A2, 5'd1, 5'd2, 5'd3, 32'h0, 32'h100);
    drive(1'b1, LUI, 32'h104);  tick(); bundle("lui", 10'h0C3, 5'd0, 5'd5, 5'd5, 32'h12340000, 32'h104);
    drive(1'b1, BEQ, 32'h108);  tick(); bundle("beq", 10'h106, 5'd1, 5'd2, 5'd0, 32'hFFFFFFFF, 32'h108);
    drive(1'b1, ORI, 32'h10C);  tick(); bundle("ori", 10'h0C1, 5'd1, 5'd7, 5'd7, 32'h00008001, 32'h10C);
    drive(1'b1, JMP, 32'h110);  tick(); bundle("j",   10'h200, 5'd31, 5'd31, 5'd0, 32'h03FFFFFF, 32'h110);
    drive(1'b1, NOPR, 32'h114); tick(); bundle("rf0", 10'h020, 5'd1, 5'd2, 5'd0, 32'h0, 32'h114);
    drive(1'b1, BAD, 32'h118);  tick(); bundle("bad", 10'h000, 5'd31, 5'd31, 5'd0, 32'h0, 32'h118);
    drive(1'b1, SUB, 32'h11C);  tick(); bundle("sub", 10'h0A6, 5'd1, 5'd2, 5'd4, 32'h0, 32'h11C);
    drive(1'b1, SW, 32'h120);   tick(); bundle("sw",  10'h052, 5'd1, 5'd2, 5'd0, 32'h8, 32'h120);

    // Downstream stall: bundle holds, nothing accepted
    out_ready = 1'b0;
    drive(1'b1, ADD1, 32'h200);
    for (int i = 0; i < 3; i++) begin
      chk("stall.in_ready", 64'(in_ready), 64'd0);
      tick();
      bundle("stall", 10'h052, 5'd1, 5'd2, 5'd0, 32'h8, 32'h120);
    end
    out_ready = 1'b1;
    #1;
    chk("stall_rel.in_ready", 64'(in_ready), 64'd1);
    tick(); bundle("stall_rel", 10'h0A2, 5'd1, 5'd2, 5'd3, 32'h0, 32'h200);

    // Load-use via rs: one bubble, then the add issues
    drive(1'b1, LW, 32'h300);   tick(); bundle("lw", 10'h0CA, 5'd1, 5'd2, 5'd2, 32'hFFFFFFFC, 32'h300);
    drive(1'b1, ADD2, 32'h304);
    chk("lu.in_ready", 64'(in_ready), 64'd0);
    tick();
    chk("lu.bubble_valid", 64'(out_valid), 64'd0);
    chk("lu.bubble_cnt", 64'(bubble_cnt), 64'd1);
    chk("lu.hold_pc", 64'(out_pc), 64'h300);
    chk("lu.in_ready_after", 64'(in_ready), 64'd1);
    tick(); bundle("lu.issue", 10'h0A2, 5'd2, 5'd4, 5'd3, 32'h0, 32'h304);

    // No hazard: j and lui-like non-readers, addi writing (not reading) rt
    drive(1'b1, LW, 32'h310);   tick();
    drive(1'b1, JRS, 32'h314);
    chk("nohz_j.in_ready", 64'(in_ready), 64'd1);
    tick(); bundle("nohz_j", 10'h200, 5'd2, 5'd0, 5'd0, 32'h00400000, 32'h314);
    drive(1'b1, LW, 32'h318);   tick();
    drive(1'b1, ADDI, 32'h31C);
    chk("nohz_addi.in_ready", 64'(in_ready), 64'd1);
    tick(); bundle("nohz_addi", 10'h0C2, 5'd5, 5'd2, 5'd2, 32'h1, 32'h31C);

    // Load-use via rt on a store
    drive(1'b1, LW, 32'h320);   tick();
    drive(1'b1, SW, 32'h324);
    chk("lu_rt.in_ready", 64'(in_ready), 64'd0);
    tick();
    chk("lu_rt.bubble_valid", 64'(out_valid), 64'd0);
    chk("lu_rt.bubble_cnt", 64'(bubble_cnt), 64'd2);
    tick(); bundle("lu_rt.issue", 10'h052, 5'd1, 5'd2, 5'd0, 32'h8, 32'h324);

    // lw into $0 never stalls
    drive(1'b1, LW0, 32'h330);  tick(); bundle("lw0", 10'h0CA, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFC, 32'h330);
    drive(1'b1, ADD0, 32'h334);
    chk("lw0.in_ready", 64'(in_ready), 64'd1);
    tick(); bundle("add0", 10'h0A2, 5'd0, 5'd0, 5'd3, 32'h0, 32'h334);

    // Flush with a held bundle and downstream stalled
    out_ready = 1'b0;
    flush = 1'b1;
    drive(1'b1, ADD1, 32'h400);
    chk("flush.in_ready", 64'(in_ready), 64'd1);
    tick();
    chk("flush.valid", 64'(out_valid), 64'd0);
    chk("flush.bubble_cnt", 64'(bubble_cnt), 64'd2);
    chk("flush.hold_pc", 64'(out_pc), 64'h334);
    flush = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, ADD1, 32'h400);
    tick();
    chk("flush.dropped", 64'(out_valid), 64'd0);

    // Flush beats hazard: no bubble counted
    drive(1'b1, LW, 32'h500);   tick();
    flush = 1'b1;
    drive(1'b1, ADD2, 32'h504);
    chk("flush_hz.in_ready", 64'(in_ready), 64'd1);
    tick();
    chk("flush_hz.valid", 64'(out_valid), 64'd0);
    chk("flush_hz.bubble_cnt", 64'(bubble_cnt), 64'd2);
    flush = 1'b0;

    // Five load-use pairs: counter saturates
    exp_bub = 2;
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, LW, 32'h600);   tick();
      drive(1'b1, ADD2, 32'h604); tick();
      exp_bub = (exp_bub == 3) ? 3 : exp_bub + 1;
      chk("sat.bubble_valid", 64'(out_valid), 64'd0);
      chk("sat.bubble_cnt", 64'(bubble_cnt), 64'(exp_bub));
      tick();
      chk("sat.issue_valid", 64'(out_valid), 64'd1);
    end

    // Asynchronous reset mid-stall
    out_ready = 1'b0;
    drive(1'b1, LW, 32'h700);
    tick();
    #2;
    nrst = 1'b0;
    #1;
    all_zero("async_reset");
    tick();
    nrst = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, ADD1, 32'h704);
    chk("post_reset.in_ready", 64'(in_ready), 64'd1);
    tick(); bundle("post_reset", 10'h0A2, 5'd1, 5'd2, 5'd3, 32'h0, 32'h704);
    chk("post_reset.bubble_cnt", 64'(bubble_cnt), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 The block SHALL provide parameter XLEN, default 32, which sets the data/immediate/PC width and is at least 16.
REQ-002 The block SHALL provide parameter HAZARD_EN, default 1, which enables load-use bubble insertion when 1.
REQ-003 The block SHALL provide parameter CNT_W, default 16, which sets the bubble counter width.
REQ-004 The block SHALL provide port clk, input, 1 bit: the single clock, with all state on its rising edge.
REQ-005 The block SHALL provide port nrst, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL provide port in_valid, input, 1 bit: the fetch stage presents an instruction.
REQ-007 The block SHALL provide port in_ready, output, 1 bit: the decode stage accepts the instruction this cycle.
REQ-008 The block SHALL provide port in_inst, input, 32 bits: the MIPS instruction word.
REQ-009 The block SHALL provide port in_pc, input, XLEN bits: the instruction PC.
REQ-010 The block SHALL provide port flush, input, 1 bit: kill the held and incoming instruction (taken branch/jump).
REQ-011 The block SHALL provide port out_valid, output, 1 bit: the registered decode bundle is valid.
REQ-012 The block SHALL provide port out_ready, input, 1 bit: the execute stage accepts the bundle.
REQ-013 The block SHALL provide port out_ctrl, output, 10 bits, packed as {pc_src[1:0], we, alu_src_b, reg_dst, mem_write, mem_to_reg, alu_ctrl[2:0]}.
REQ-014 The block SHALL provide port out_rs, output, 5 bits: source register inst[25:21].
REQ-015 The block SHALL provide port out_rt, output, 5 bits: source register inst[20:16].
REQ-016 The block SHALL provide port out_dest, output, 5 bits: the write-back register index.
REQ-017 The block SHALL provide port out_imm, output, XLEN bits: the extended immediate.
REQ-018 The block SHALL provide port out_pc, output, XLEN bits: the registered in_pc.
REQ-019 The block SHALL provide port bubble_cnt, output, CNT_W bits: the count of inserted load-use bubbles.

Function
REQ-020 The opcode decode SHALL be as follows.
- 000000 R-type: pc_src=0, we=1, alu_src_b=0, reg_dst=1, mem_write=0, mem_to_reg=0.
- 001000 addi, 001100 andi, 001101 ori, 001010 slti, 001111 lui: we=1, alu_src_b=1, reg_dst=0.
- 000100 beq: pc_src=1; 000101 bne: pc_src=3; 000010 j: pc_src=2; each with we=0.
- 100011 lw: we=1, alu_src_b=1, mem_to_reg=1; 101011 sw: alu_src_b=1, mem_write=1, we=0.
- Any other opcode: all fields 0.
REQ-021 An R-type instruction with funct 000000 SHALL decode with we=0.
REQ-022 alu_ctrl SHALL be assigned as follows.
- R-type by funct: 100000→010, 100010→110, 100100→000, 100101→001, 101010→111, any other funct→000.
- addi/lw/sw→010; beq/bne→110; andi→000; ori→001; slti→111; lui→011; all else→000.
REQ-023 out_imm SHALL be produced as follows.
- Sign-extended inst[15:0] for addi, slti, lw, sw, beq, bne.
- Zero-extended for andi and ori.
- {inst[15:0], 16'b0} zero-extended to XLEN for lui.
- Zero-extended inst[25:0] for j.
- 0 otherwise.
REQ-024 out_dest SHALL equal inst[15:11] when reg_dst=1, inst[20:16] when reg_dst=0, and 0 when we=0.
REQ-025 The output register SHALL be a single pipeline stage: latency from in_valid&&in_ready to out_valid is exactly 1 cycle.
REQ-026 The register SHALL advance (load) when out_ready||!out_valid.
REQ-027 While out_valid=1 and out_ready=0, all out_* SHALL hold stable.
REQ-028 Hazard SHALL be asserted when HAZARD_EN=1, out_valid=1, out_ctrl marks lw (mem_to_reg=1), out_dest!=0, and in_valid=1 and the incoming instruction reads out_dest.
- The incoming instruction reads rs for every opcode except j and lui.
- The incoming instruction also reads rt for R-type, beq, bne and sw.
REQ-029 in_ready SHALL equal (out_ready||!out_valid) && !hazard, or 1 when flush=1.
REQ-030 On an advance with hazard=1, the register SHALL load a bubble (out_valid=0) and bubble_cnt SHALL increment, saturating at all-ones.
REQ-031 flush=1 SHALL clear out_valid next cycle regardless of out_ready, SHALL consume and discard any incoming instruction, and SHALL take priority over hazard (no bubble counted).
REQ-032 Bubbles and invalid bundles SHALL leave the out_* data fields at their previous values; only out_valid is defined for them.
REQ-033 A hazard SHALL insert exactly one bubble, because the following cycle the register no longer holds the lw.

Reset
REQ-034 While nrst=0, out_valid, out_ctrl, out_rs, out_rt, out_dest, out_imm, out_pc and bubble_cnt SHALL all be 0.
REQ-035 While nrst=0, in_ready SHALL be 0, and the first accept SHALL occur on the first rising edge after release.
REQ-036 Reset asserted mid-stall SHALL discard the held bundle with no partial state retained.

Verification
REQ-037 add $3,$1,$2 (0x00221820), out_ready=1: the next cycle SHALL give out_valid=1, out_ctrl=10'b00_1_0_1_0_0_010, out_dest=3.
REQ-038 lw $2,-4($1) followed by add $3,$2,$4: exactly one cycle SHALL show in_ready=0 and out_valid=0, bubble_cnt SHALL read 1, and the add SHALL issue the cycle after.
REQ-039 lui $5,0x1234 with XLEN=32: the bench SHALL see out_imm=0x12340000 and out_ctrl alu_ctrl=011.
REQ-040 out_ready=0 for 3 cycles with a valid bundle: the bench SHALL see out_* stable and in_ready=0; releasing out_ready SHALL accept the next instruction.
REQ-041 flush=1 with a valid held bundle and in_valid=1: the next cycle SHALL give out_valid=0, bubble_cnt unchanged, and the incoming instruction dropped.
REQ-042 CNT_W=2 and five load-use pairs: the bench SHALL see bubble_cnt saturate at 3; nrst pulsed low mid-stream SHALL return all outputs to 0 asynchronously.
